// File: rtl/vga_sync_generator_pkg.sv
// Shared VGA timing constants, quadrant encodings and helpers.
// The colour manager uses the same quadrant codes as its colour-slot address.
// Defaults describe 640x480@60 with a 2-clock pixel period.
package vga_sync_generator_pkg;

  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam bit          DEF_SYNC_POL = 1'b0;
  localparam int unsigned DEF_X_WIDTH  = 10;
  localparam int unsigned DEF_Y_WIDTH  = 10;

  // Full period of one axis: visible + front porch + sync + back porch.
  function automatic int unsigned axis_total(input int unsigned active_len,
                                             input int unsigned fp_len,
                                             input int unsigned sync_len,
                                             input int unsigned bp_len);
    return active_len + fp_len + sync_len + bp_len;
  endfunction

  localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Quadrant code is {down, right}.
  typedef enum logic [1:0] {
    QUAD_LEFT_UP    = 2'b00,
    QUAD_RIGHT_UP   = 2'b01,
    QUAD_LEFT_DOWN  = 2'b10,
    QUAD_RIGHT_DOWN = 2'b11
  } quad_t;

  function automatic quad_t quad_code(input logic down, input logic right);
    return quad_t'({down, right});
  endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// Timing bundle between the sync generator (master) and the colour manager (slave).
// Enable flows from the consumer side; everything else flows from the generator.
// Widths follow the coordinate counter widths of the generator.
interface vga_sync_generator_if #(
  parameter int unsigned X_WIDTH = 10,
  parameter int unsigned Y_WIDTH = 10
);
  import vga_sync_generator_pkg::*;

  logic               Enable;
  logic               Pixel_Tick;
  logic               HSync;
  logic               VSync;
  logic               Active;
  logic [X_WIDTH-1:0] Pixel_X;
  logic [Y_WIDTH-1:0] Pixel_Y;
  quad_t              Quadrant;
  logic               Frame_Start;

  modport master (
    input  Enable,
    output Pixel_Tick, HSync, VSync, Active, Pixel_X, Pixel_Y, Quadrant, Frame_Start
  );

  modport slave (
    output Enable,
    input  Pixel_Tick, HSync, VSync, Active, Pixel_X, Pixel_Y, Quadrant, Frame_Start
  );

endinterface

// File: rtl/vga_sync_generator_axis_counter.sv
// Wrap counter for one screen axis with carry-out and sync/active/half window decode.
// Latency: count updates on the edge where inc_i is high; decodes are combinational on the count.
// Backpressure: none; the counter only moves when inc_i is asserted.
module vga_sync_generator_axis_counter
  import vga_sync_generator_pkg::*;
#(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48
)(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             carry_o,
  output logic             sync_o,
  output logic             active_o,
  output logic             upper_o
);

  localparam int unsigned      TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] SYNC_START = WIDTH'(ACTIVE + FP);
  localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(ACTIVE + FP + SYNC - 1);
  localparam logic [WIDTH-1:0] ACT_END    = WIDTH'(ACTIVE);
  localparam logic [WIDTH-1:0] HALF       = WIDTH'(ACTIVE / 2);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);
  assign carry_o = inc_i && at_last;

  // Advance on increment, wrapping from the last position straight to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Position register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign sync_o   = (cnt_q >= SYNC_START) && (cnt_q <= SYNC_END);
  assign active_o = (cnt_q < ACT_END);
  assign upper_o  = (cnt_q >= HALF);

endmodule

// File: rtl/vga_sync_generator.sv
// VGA timing source: HSync/VSync, active window, pixel coordinates, quadrant, frame pulse.
// Latency: each tick registers the decode of the pixel it consumes; visible one Clk after the tick edge.
// Backpressure: Enable low freezes divider, counters and levels; Pixel_Tick/Frame_Start stay low.
module vga_sync_generator
  import vga_sync_generator_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = DEF_SYNC_POL,
  parameter int unsigned X_WIDTH  = DEF_X_WIDTH,
  parameter int unsigned Y_WIDTH  = DEF_Y_WIDTH
)(
  input  logic                 Clk,
  input  logic                 rst,
  vga_sync_generator_if.master vga
);

  // A one-wide divider still works for CLK_DIV=1: it stays at zero and every enabled Clk ticks.
  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_d;
  logic               tick;

  logic [X_WIDTH-1:0] h_cnt;
  logic [Y_WIDTH-1:0] v_cnt;
  logic               h_carry, v_carry;
  logic               h_sync, v_sync;
  logic               h_act, v_act;
  logic               h_upper, v_upper;
  logic               in_active;

  logic               pixel_tick_q;
  logic               frame_start_q;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               active_q, active_d;
  logic [X_WIDTH-1:0] pixel_x_q, pixel_x_d;
  logic [Y_WIDTH-1:0] pixel_y_q, pixel_y_d;
  quad_t              quadrant_q, quadrant_d;

  assign tick = vga.Enable && (div_q == DIV_LAST);

  // Pixel-rate divider: counts enabled Clks, restarting after each tick.
  always_comb begin
    div_d = div_q;
    if (vga.Enable) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  vga_sync_generator_axis_counter #(
    .WIDTH (X_WIDTH),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP)
  ) u_h_axis (
    .clk_i   (Clk),
    .rst_i   (rst),
    .inc_i   (tick),
    .cnt_o   (h_cnt),
    .carry_o (h_carry),
    .sync_o  (h_sync),
    .active_o(h_act),
    .upper_o (h_upper)
  );

  // The line counter steps on the horizontal wrap, so both wraps land on the same edge.
  vga_sync_generator_axis_counter #(
    .WIDTH (Y_WIDTH),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP)
  ) u_v_axis (
    .clk_i   (Clk),
    .rst_i   (rst),
    .inc_i   (h_carry),
    .cnt_o   (v_cnt),
    .carry_o (v_carry),
    .sync_o  (v_sync),
    .active_o(v_act),
    .upper_o (v_upper)
  );

  assign in_active = h_act && v_act;

  // Level outputs capture the decode of the pixel consumed by the tick and hold in between.
  always_comb begin
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    active_d   = active_q;
    pixel_x_d  = pixel_x_q;
    pixel_y_d  = pixel_y_q;
    quadrant_d = quadrant_q;
    if (tick) begin
      hsync_d    = h_sync ? SYNC_POL : ~SYNC_POL;
      vsync_d    = v_sync ? SYNC_POL : ~SYNC_POL;
      active_d   = in_active;
      pixel_x_d  = in_active ? h_cnt : '0;
      pixel_y_d  = in_active ? v_cnt : '0;
      quadrant_d = in_active ? quad_code(v_upper, h_upper) : QUAD_LEFT_UP;
    end
  end

  // Output registers; pulses come from the same edge as the level update they accompany.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      active_q      <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      quadrant_q    <= QUAD_LEFT_UP;
    end else begin
      pixel_tick_q  <= tick;
      frame_start_q <= v_carry;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      quadrant_q    <= quadrant_d;
    end
  end

  assign vga.Pixel_Tick  = pixel_tick_q;
  assign vga.Frame_Start = frame_start_q;
  assign vga.HSync       = hsync_q;
  assign vga.VSync       = vsync_q;
  assign vga.Active      = active_q;
  assign vga.Pixel_X     = pixel_x_q;
  assign vga.Pixel_Y     = pixel_y_q;
  assign vga.Quadrant    = quadrant_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator on a shrunken 24x13 raster with a 2-clock pixel period.
// A pixel-index model predicts every Clk's outputs into a queue; a monitor pops and compares.
// Directed waits measure tick delay, sync widths, frame period and reset behaviour.
module tb_vga_sync_generator;
  import vga_sync_generator_pkg::*;

  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam bit SYNC_POL = 1'b0;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL * CLK_DIV;

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] q;
    logic       fs;
  } obs_t;

  localparam obs_t RESET_OBS = '{tick: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, act: 1'b0,
                                 x: 10'd0, y: 10'd0, q: 2'b00, fs: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  obs_t exp_q[$];

  vga_sync_generator_if #(.X_WIDTH(10), .Y_WIDTH(10)) vga ();

  vga_sync_generator #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL),
    .X_WIDTH (10),
    .Y_WIDTH (10)
  ) dut (
    .Clk(clk),
    .rst(rst),
    .vga(vga)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.tick = vga.Pixel_Tick;
    o.hs   = vga.HSync;
    o.vs   = vga.VSync;
    o.act  = vga.Active;
    o.x    = vga.Pixel_X;
    o.y    = vga.Pixel_Y;
    o.q    = vga.Quadrant;
    o.fs   = vga.Frame_Start;
    return o;
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       sig = vga.Pixel_Tick;
      1:       sig = vga.HSync;
      2:       sig = vga.VSync;
      3:       sig = vga.Frame_Start;
      4:       sig = (vga.Pixel_Y == 10'd6);
      default: sig = 1'b0;
    endcase
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got tick=%0b hs=%0b vs=%0b act=%0b x=%0d y=%0d q=%0d fs=%0b, expected tick=%0b hs=%0b vs=%0b act=%0b x=%0d y=%0d q=%0d fs=%0b",
                  name, $time, act.tick, act.hs, act.vs, act.act, act.x, act.y, act.q, act.fs,
                  exp.tick, exp.hs, exp.vs, exp.act, exp.x, exp.y, exp.q, exp.fs);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_found(input string name, input int n);
    total_cnt++;
    if (n >= 0) pass_cnt++;
    else $display("FAIL %s: condition not seen within cycle budget (got timeout, expected event)", name);
  endtask

  // Counts falling edges until the selected signal equals val; n = -1 when the budget runs out.
  task automatic cycles_until(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (sig(sel) === val) break;
      if (n >= limit) begin
        n = -1;
        break;
      end
    end
  endtask

  // Reference model: a tick consumes pixel index p; its raster position is plain div/mod of p.
  initial begin : model
    int   ec;
    int   p, h, v;
    bit   a;
    obs_t lv;
    ec = 0;
    lv = RESET_OBS;
    forever begin
      @(posedge clk);
      lv.tick = 1'b0;
      lv.fs   = 1'b0;
      if (rst) begin
        ec = 0;
        lv = RESET_OBS;
      end else if (vga.Enable) begin
        ec++;
        if (ec % CLK_DIV == 0) begin
          p = ec / CLK_DIV - 1;
          h = p % H_TOTAL;
          v = (p / H_TOTAL) % V_TOTAL;
          a = (h < H_ACTIVE) && (v < V_ACTIVE);
          lv.tick = 1'b1;
          lv.hs   = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
          lv.vs   = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
          lv.act  = a;
          lv.x    = a ? 10'(h) : 10'd0;
          lv.y    = a ? 10'(v) : 10'd0;
          lv.q    = a ? {(v >= V_ACTIVE / 2), (h >= H_ACTIVE / 2)} : 2'b00;
          lv.fs   = (h == H_TOTAL - 1) && (v == V_TOTAL - 1);
        end
      end
      exp_q.push_back(lv);
    end
  end

  // Monitor: every falling edge the DUT presents a full output set; compare with the oldest prediction.
  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_obs("scoreboard", sample(), e);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int ticks;
    vga.Enable = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_obs("reset_state", sample(), RESET_OBS);

    // Release reset with Enable high and time the first pixel.
    #1 rst = 1'b0;
    cycles_until(0, 1'b1, 10, n);
    check_int("first_tick_delay", n, CLK_DIV);
    check_int("first_pixel_active", int'(vga.Active), 1);
    check_int("first_pixel_x", int'(vga.Pixel_X), 0);
    check_int("first_pixel_y", int'(vga.Pixel_Y), 0);

    // Horizontal and vertical sync widths.
    cycles_until(1, SYNC_POL, 4 * H_TOTAL * CLK_DIV, n);
    check_found("hsync_start", n);
    cycles_until(1, ~SYNC_POL, 4 * H_TOTAL * CLK_DIV, n);
    check_int("hsync_width", n, H_SYNC * CLK_DIV);
    cycles_until(2, SYNC_POL, 2 * FRAME, n);
    check_found("vsync_start", n);
    cycles_until(2, ~SYNC_POL, 2 * FRAME, n);
    check_int("vsync_width", n, V_SYNC * H_TOTAL * CLK_DIV);

    // Frame pulse width and spacing.
    cycles_until(3, 1'b1, 2 * FRAME, n);
    check_found("frame_start_seen", n);
    cycles_until(3, 1'b0, 4, n);
    check_int("frame_start_width", n, 1);
    cycles_until(3, 1'b1, 2 * FRAME, n);
    check_int("frame_period", n, FRAME - 1);

    // Freeze inside horizontal sync for 100 Clk, then resume.
    cycles_until(1, SYNC_POL, 4 * H_TOTAL * CLK_DIV, n);
    check_found("freeze_point", n);
    #1 vga.Enable = 1'b0;
    ticks = 0;
    repeat (100) begin
      @(negedge clk);
      if (vga.Pixel_Tick || vga.Frame_Start) ticks++;
    end
    check_int("freeze_no_pulses", ticks, 0);
    check_int("freeze_hsync_held", int'(vga.HSync), int'(SYNC_POL));
    #1 vga.Enable = 1'b1;

    // Randomly gated Enable over several frames.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      #1 vga.Enable = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    #1 vga.Enable = 1'b1;

    // Reset mid-frame: immediate reset values, then a full-length frame with no early pulse.
    cycles_until(4, 1'b1, 2 * FRAME, n);
    check_found("row6_reached", n);
    #1 rst = 1'b1;
    #1 check_obs("reset_midframe", sample(), RESET_OBS);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    cycles_until(3, 1'b1, 2 * FRAME, n);
    check_int("post_reset_frame", n, FRAME);

    repeat (4) @(negedge clk);
    #2 check_int("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
